// File: rtl/lstm_enc_pkg.sv
// Shared sizing, constants and FSM encoding for the LSTM character front end.
// No logic; latency and backpressure are defined by the modules that import it.
// Optional build macro used by importers: CHAR_WINDOW_BOUNDS_CHECK_EN.
package lstm_enc_pkg;
  localparam int SEQ_LENGTH = 4;
  localparam int ENC        = 27;
  localparam int BW         = 32;
  localparam int CW         = 6;
  localparam int GW         = 8;
  localparam int WORD_W     = BW * ENC * SEQ_LENGTH;
  localparam int FILL_W     = $clog2(SEQ_LENGTH + 1);

  localparam logic [BW-1:0] FP_ONE = 32'h3F80_0000;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ISSUE,
    WAIT,
    DONE
  } state_t;
endpackage

// File: rtl/one_hot_fp_encoder.sv
// Character index to one-hot float32 vector; indices >= ENC give all zeros.
// Purely combinational, zero latency, no backpressure.
module one_hot_fp_encoder
  import lstm_enc_pkg::*;
(
  input  logic [CW-1:0]     idx,
  output logic [BW*ENC-1:0] vec
);

  always_comb begin
    vec = '0;
    for (int k = 0; k < ENC; k++) begin
      if (idx == CW'(k)) vec[k*BW +: BW] = FP_ONE;
    end
  end

endmodule

// File: rtl/char_window_encoder.sv
// Sliding SEQ_LENGTH-char window, issued one-hot to the forward pass, fed back autoregressively.
// pred_valid at t -> out_valid and refreshed word/word_valid at t+1; word held while word_valid&!word_ready.
// CHAR_WINDOW_BOUNDS_CHECK_EN adds the out-of-range index check and sticky err.
module char_window_encoder
  import lstm_enc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [GW-1:0]     gen_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW-1:0]     in_char,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [WORD_W-1:0] word,
  input  logic              pred_valid,
  input  logic [CW-1:0]     pred_char,
  output logic              out_valid,
  output logic [CW-1:0]     out_char,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t              state;
  logic [CW-1:0]       win     [SEQ_LENGTH];
  logic [CW-1:0]       win_nxt [SEQ_LENGTH];
  logic [GW-1:0]       remaining;
  logic [FILL_W-1:0]   fill_cnt;
  logic [WORD_W-1:0]   word_nxt;
  logic                seed_acc;
  logic                pred_acc;
  logic                seed_ok;
  logic                pred_ok;
  logic                shift_en;
  logic [CW-1:0]       shift_char;

  assign seed_acc = (state == FILL) && in_valid && in_ready;
  assign pred_acc = (state == WAIT) && pred_valid;

`ifdef CHAR_WINDOW_BOUNDS_CHECK_EN
  assign seed_ok = (in_char < CW'(ENC));
  assign pred_ok = (pred_char < CW'(ENC));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if ((seed_acc && !seed_ok) || (pred_acc && !pred_ok)) begin
      err <= 1'b1;
    end
  end
`else
  assign seed_ok = 1'b1;
  assign pred_ok = 1'b1;
  assign err     = 1'b0;
`endif

  assign shift_en = (seed_acc && seed_ok) || pred_acc;

  // A rejected prediction still advances the window, but with a blank slot.
  always_comb begin
    shift_char = CW'(ENC);
    if (seed_acc)     shift_char = in_char;
    else if (pred_ok) shift_char = pred_char;
  end

  always_comb begin
    for (int s = 0; s < SEQ_LENGTH - 1; s++) begin
      win_nxt[s] = shift_en ? win[s+1] : win[s];
    end
    win_nxt[SEQ_LENGTH-1] = shift_en ? shift_char : win[SEQ_LENGTH-1];
  end

  // Encoding the next window lets word land on the same edge as the shift.
  for (genvar s = 0; s < SEQ_LENGTH; s++) begin : g_enc
    one_hot_fp_encoder u_enc (
      .idx (win_nxt[s]),
      .vec (word_nxt[s*BW*ENC +: BW*ENC])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      for (int s = 0; s < SEQ_LENGTH; s++) win[s] <= CW'(ENC);
      word       <= '0;
      word_valid <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_char   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      remaining  <= '0;
      fill_cnt   <= '0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      for (int s = 0; s < SEQ_LENGTH; s++) win[s] <= win_nxt[s];
      word      <= word_nxt;

      case (state)
        IDLE: begin
          if (start) begin
            remaining <= gen_len;
            fill_cnt  <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            state     <= FILL;
          end
        end
        FILL: begin
          if (seed_acc && seed_ok) begin
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt == FILL_W'(SEQ_LENGTH - 1)) begin
              in_ready <= 1'b0;
              if (remaining != '0) begin
                word_valid <= 1'b1;
                state      <= ISSUE;
              end else begin
                done  <= 1'b1;
                state <= DONE;
              end
            end
          end
        end
        ISSUE: begin
          if (word_ready) begin
            word_valid <= 1'b0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (pred_valid) begin
            out_valid <= 1'b1;
            out_char  <= pred_char;
            remaining <= remaining - 1'b1;
            if (remaining != GW'(1)) begin
              word_valid <= 1'b1;
              state      <= ISSUE;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_char_window_encoder.sv
// Directed bench for char_window_encoder: job table plus reset and bounds sequences.
`timescale 1ns/1ps
module tb_char_window_encoder;
  import lstm_enc_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [GW-1:0]     gen_len;
  logic              in_valid;
  logic              in_ready;
  logic [CW-1:0]     in_char;
  logic              word_valid;
  logic              word_ready;
  logic [WORD_W-1:0] word;
  logic              pred_valid;
  logic [CW-1:0]     pred_char;
  logic              out_valid;
  logic [CW-1:0]     out_char;
  logic              busy;
  logic              done;
  logic              err;

  int n_cmp = 0;
  int n_err = 0;
  int out_cnt = 0;

  typedef struct packed {
    logic [3:0][5:0] seed;
    logic [7:0]      gen;
    logic [2:0][5:0] pred;
    logic [3:0][5:0] fin;
    logic [3:0]      hold;
  } job_t;

  job_t jobs [4];

  char_window_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .gen_len    (gen_len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_char    (in_char),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word       (word),
    .pred_valid (pred_valid),
    .pred_char  (pred_char),
    .out_valid  (out_valid),
    .out_char   (out_char),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (out_valid === 1'b1) out_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] enc_word(input logic [3:0][5:0] idx);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int s = 0; s < SEQ_LENGTH; s++)
      for (int k = 0; k < ENC; k++)
        if (int'(idx[s]) == k) w[s*BW*ENC + k*BW +: BW] = 32'h3F80_0000;
    return w;
  endfunction

  function automatic int slot_idx(input logic [WORD_W-1:0] w, input int s);
    int r;
    logic [BW*ENC-1:0] v;
    v = w[s*BW*ENC +: BW*ENC];
    r = (v == '0) ? ENC : 63;
    for (int k = 0; k < ENC; k++)
      if (v[k*BW +: BW] == 32'h3F80_0000) r = k;
    return r;
  endfunction

  task automatic chk_word(input string name, input logic [3:0][5:0] idx);
    logic [WORD_W-1:0] exp;
    exp = enc_word(idx);
    n_cmp++;
    if (word !== exp) begin
      n_err++;
      $display("FAIL %s: got slots %0d,%0d,%0d,%0d expected slots %0d,%0d,%0d,%0d", name,
               slot_idx(word, 0), slot_idx(word, 1), slot_idx(word, 2), slot_idx(word, 3),
               idx[0], idx[1], idx[2], idx[3]);
    end
  endtask

  task automatic feed(input logic [5:0] c);
    int  t;
    logic acc;
    t = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_char  = c;
    while (!acc && t < 20) begin
      acc = in_ready;
      tick();
      t++;
    end
    in_valid = 1'b0;
    if (!acc) chk("seed_accept_timeout", 0, 1);
  endtask

  task automatic run_job(input job_t j);
    logic [3:0][5:0] w;
    int base;
    base = out_cnt;
    start = 1'b1;
    gen_len = j.gen;
    pred_valid = 1'b1;
    pred_char = 6'd13;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("in_ready_in_fill", in_ready, 1);
    for (int i = 0; i < 4; i++) feed(j.seed[i]);
    pred_valid = 1'b0;
    chk("in_ready_after_fill", in_ready, 0);
    w = j.seed;
    if (j.gen == 0) begin
      chk("done_gen0", done, 1);
      chk("word_valid_gen0", word_valid, 0);
    end
    for (int k = 0; k < int'(j.gen); k++) begin
      chk("word_valid_issue", word_valid, 1);
      chk_word("issue_word", w);
      for (int h = 0; h < int'(j.hold); h++) begin
        pred_valid = 1'b1;
        pred_char = 6'd11;
        tick();
        chk("word_valid_hold", word_valid, 1);
        chk_word("word_hold", w);
      end
      pred_valid = 1'b1;
      pred_char = 6'd12;
      word_ready = 1'b1;
      tick();
      word_ready = 1'b0;
      pred_valid = 1'b0;
      chk("word_valid_after_hs", word_valid, 0);
      tick();
      chk("no_out_in_wait", out_valid, 0);
      pred_valid = 1'b1;
      pred_char = j.pred[k];
      tick();
      pred_valid = 1'b0;
      chk("out_valid", out_valid, 1);
      chk("out_char", out_char, j.pred[k]);
      w = {j.pred[k], w[3], w[2], w[1]};
      if (k == int'(j.gen) - 1) chk("done_last", done, 1);
      else                      chk("busy_mid", busy, 1);
    end
    chk_word("final_window", j.fin);
    chk("word_valid_at_done", word_valid, 0);
    tick();
    chk("done_one_cycle", done, 0);
    chk("busy_idle", busy, 0);
    chk("out_count", out_cnt - base, j.gen);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; gen_len = '0; in_valid = 1'b0; in_char = '0;
    word_ready = 1'b0; pred_valid = 1'b0; pred_char = '0;

    jobs[0] = '{seed: {6'd4, 6'd3, 6'd2, 6'd1},   gen: 8'd0, pred: {6'd0, 6'd0, 6'd0},
                fin: {6'd4, 6'd3, 6'd2, 6'd1},    hold: 4'd0};
    jobs[1] = '{seed: {6'd4, 6'd3, 6'd2, 6'd1},   gen: 8'd1, pred: {6'd0, 6'd0, 6'd7},
                fin: {6'd7, 6'd4, 6'd3, 6'd2},    hold: 4'd0};
    jobs[2] = '{seed: {6'd5, 6'd26, 6'd0, 6'd10}, gen: 8'd3, pred: {6'd9, 6'd8, 6'd7},
                fin: {6'd9, 6'd8, 6'd7, 6'd5},    hold: 4'd5};
    jobs[3] = '{seed: {6'd3, 6'd3, 6'd3, 6'd3},   gen: 8'd2, pred: {6'd0, 6'd0, 6'd26},
                fin: {6'd0, 6'd26, 6'd3, 6'd3},   hold: 4'd2};

    tick();
    tick();
    rst_n = 1'b1;
    chk_word("reset_word", {6'd27, 6'd27, 6'd27, 6'd27});
    chk("reset_busy", busy, 0);
    chk("reset_word_valid", word_valid, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_char", out_char, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);

    for (int r = 0; r < 3; r++) run_job(jobs[r]);

    // Abort from WAIT, then confirm a clean restart.
    start = 1'b1; gen_len = 8'd2;
    tick();
    start = 1'b0;
    feed(6'd1); feed(6'd2); feed(6'd3); feed(6'd4);
    chk("abort_issue", word_valid, 1);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", busy, 0);
    chk("abort_word_valid", word_valid, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_char", out_char, 0);
    chk("abort_done", done, 0);
    chk_word("abort_word", {6'd27, 6'd27, 6'd27, 6'd27});
    pred_valid = 1'b1; pred_char = 6'd5;
    tick();
    pred_valid = 1'b0;
    chk("idle_pred_ignored", out_valid, 0);
    chk("abort_no_done", done, 0);

    run_job(jobs[3]);

    start = 1'b1; gen_len = 8'd0;
    tick();
    start = 1'b0;
`ifdef CHAR_WINDOW_BOUNDS_CHECK_EN
    feed(6'd30); feed(6'd1); feed(6'd2); feed(6'd3); feed(6'd4);
    chk("bounds_done", done, 1);
    tick();
    chk_word("bounds_window", {6'd4, 6'd3, 6'd2, 6'd1});
    chk("bounds_err", err, 1);
`else
    feed(6'd30); feed(6'd2); feed(6'd3); feed(6'd4);
    chk("raw_done", done, 1);
    tick();
    chk_word("raw_window", {6'd4, 6'd3, 6'd2, 6'd27});
    chk("raw_err", err, 0);
`endif
    chk("final_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
